// File: rtl/wb_stage.sv
// Write-back stage: register-file write port, HI/LO registers, a small CP0
// (COUNT, STATUS, CAUSE, EPC), and exception / eret PC redirect.
//
// Handshake: the stage completes every instruction in one cycle. WB_valid
// marks the slot as live and there is no back-pressure, so WB_over simply
// mirrors WB_valid. A slot with WB_valid=0 changes nothing but COUNT.
module wb_stage #(
  parameter logic [31:0] EXC_ENTER_ADDR = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         WB_valid,
  input  logic [118:0] MEM_WB_bus_r,
  output logic         rf_wen,
  output logic [4:0]   rf_wdest,
  output logic [31:0]  rf_wdata,
  output logic         WB_over,
  output logic [4:0]   WB_wdest,
  output logic         exc_valid,
  output logic [31:0]  exc_pc,
  output logic [31:0]  WB_pc,
  output logic [31:0]  hi_out,
  output logic [31:0]  lo_out
);

  localparam logic [7:0] ADDR_COUNT  = 8'h48;
  localparam logic [7:0] ADDR_STATUS = 8'h60;
  localparam logic [7:0] ADDR_CAUSE  = 8'h68;
  localparam logic [7:0] ADDR_EPC    = 8'h70;

  localparam logic [4:0] EXC_CODE_OV  = 5'd12;
  localparam logic [4:0] EXC_CODE_SYS = 5'd8;

  // Bus fields
  logic        bus_rf_wen;
  logic [4:0]  bus_rf_wdest;
  logic [31:0] mem_result;
  logic [31:0] lo_result;
  logic        hi_write;
  logic        lo_write;
  logic        mfhi;
  logic        mflo;
  logic        mtc0;
  logic        mfc0;
  logic [7:0]  cp0r_addr;
  logic        syscall;
  logic        eret;
  logic        overflow;
  logic [31:0] pc;

  assign bus_rf_wen   = MEM_WB_bus_r[118];
  assign bus_rf_wdest = MEM_WB_bus_r[117:113];
  assign mem_result   = MEM_WB_bus_r[112:81];
  assign lo_result    = MEM_WB_bus_r[80:49];
  assign hi_write     = MEM_WB_bus_r[48];
  assign lo_write     = MEM_WB_bus_r[47];
  assign mfhi         = MEM_WB_bus_r[46];
  assign mflo         = MEM_WB_bus_r[45];
  assign mtc0         = MEM_WB_bus_r[44];
  assign mfc0         = MEM_WB_bus_r[43];
  assign cp0r_addr    = MEM_WB_bus_r[42:35];
  assign syscall      = MEM_WB_bus_r[34];
  assign eret         = MEM_WB_bus_r[33];
  assign overflow     = MEM_WB_bus_r[32];
  assign pc           = MEM_WB_bus_r[31:0];

  // Architectural state
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] count_q;
  logic [31:0] status_q;
  logic [31:0] cause_q;
  logic [31:0] epc_q;

  // Slot classification. Overflow outranks syscall, which outranks eret.
  logic commit;
  logic take_exc;
  logic take_eret;
  logic mtc0_commit;

  assign commit      = WB_valid & ~overflow & ~syscall & ~eret;
  assign take_exc    = WB_valid & (overflow | syscall);
  assign take_eret   = WB_valid & ~overflow & ~syscall & eret;
  assign mtc0_commit = commit & mtc0;

  // HI/LO update; both may be written by one instruction
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (commit) begin
      if (hi_write) hi_q <= mem_result;
      if (lo_write) lo_q <= lo_result;
    end
  end

  // COUNT free-runs; a committed mtc0 to COUNT overrides the increment
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else if (mtc0_commit && (cp0r_addr == ADDR_COUNT)) begin
      count_q <= mem_result;
    end else begin
      count_q <= count_q + 32'd1;
    end
  end

  // STATUS/CAUSE/EPC: exception entry and eret take precedence over mtc0
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status_q <= '0;
      cause_q  <= '0;
      epc_q    <= '0;
    end else if (take_exc) begin
      epc_q       <= pc;
      status_q[1] <= 1'b1;
      cause_q[6:2] <= overflow ? EXC_CODE_OV : EXC_CODE_SYS;
    end else if (take_eret) begin
      status_q[1] <= 1'b0;
    end else if (mtc0_commit) begin
      case (cp0r_addr)
        ADDR_STATUS: status_q      <= mem_result;
        ADDR_CAUSE:  cause_q[9:8]  <= mem_result[9:8];
        ADDR_EPC:    epc_q         <= mem_result;
        default:     ;
      endcase
    end
  end

  // CP0 read port; unmapped addresses read as zero
  logic [31:0] cp0_rdata;

  always_comb begin
    cp0_rdata = '0;
    case (cp0r_addr)
      ADDR_COUNT:  cp0_rdata = count_q;
      ADDR_STATUS: cp0_rdata = status_q;
      ADDR_CAUSE:  cp0_rdata = cause_q;
      ADDR_EPC:    cp0_rdata = epc_q;
      default:     cp0_rdata = '0;
    endcase
  end

  // Register-file write data select (no bypass of same-cycle HI/LO writes)
  always_comb begin
    rf_wdata = mem_result;
    if (mfhi)      rf_wdata = hi_q;
    else if (mflo) rf_wdata = lo_q;
    else if (mfc0) rf_wdata = cp0_rdata;
  end

  // Redirect request; held low while reset is asserted
  always_comb begin
    exc_valid = 1'b0;
    exc_pc    = '0;
    if (resetn && take_exc) begin
      exc_valid = 1'b1;
      exc_pc    = EXC_ENTER_ADDR;
    end else if (resetn && take_eret) begin
      exc_valid = 1'b1;
      exc_pc    = epc_q;
    end
  end

  assign rf_wen   = WB_valid & bus_rf_wen & ~overflow;
  assign rf_wdest = bus_rf_wdest;
  assign WB_over  = WB_valid;
  assign WB_wdest = bus_rf_wdest & {5{WB_valid}};
  assign WB_pc    = pc;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus random instructions, with
// expected outputs queued at drive time and compared when sampled.
module tb_wb_stage;

  typedef struct packed {
    logic        rf_wen;
    logic [4:0]  wdest;
    logic [31:0] mem;
    logic [31:0] lo;
    logic        hi_w;
    logic        lo_w;
    logic        mfhi;
    logic        mflo;
    logic        mtc0;
    logic        mfc0;
    logic [7:0]  addr;
    logic        sys;
    logic        eret;
    logic        ovf;
    logic [31:0] pc;
  } bus_t;

  typedef struct packed {
    logic        wen;
    logic [4:0]  wdest;
    logic [31:0] wdata;
    logic        exc;
    logic [31:0] exc_pc;
    logic [4:0]  wb_wdest;
    logic        over;
    logic [31:0] pc;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  localparam int EW = $bits(exp_t);
  localparam logic [31:0] EXC_ADDR = 32'h0000_0000;

  // Clock / reset
  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         WB_valid = 1'b0;
  logic [118:0] MEM_WB_bus_r = '0;
  logic         rf_wen;
  logic [4:0]   rf_wdest;
  logic [31:0]  rf_wdata;
  logic         WB_over;
  logic [4:0]   WB_wdest;
  logic         exc_valid;
  logic [31:0]  exc_pc;
  logic [31:0]  WB_pc;
  logic [31:0]  hi_out;
  logic [31:0]  lo_out;

  always #5 clk = ~clk;

  wb_stage #(.EXC_ENTER_ADDR(EXC_ADDR)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .WB_valid     (WB_valid),
    .MEM_WB_bus_r (MEM_WB_bus_r),
    .rf_wen       (rf_wen),
    .rf_wdest     (rf_wdest),
    .rf_wdata     (rf_wdata),
    .WB_over      (WB_over),
    .WB_wdest     (WB_wdest),
    .exc_valid    (exc_valid),
    .exc_pc       (exc_pc),
    .WB_pc        (WB_pc),
    .hi_out       (hi_out),
    .lo_out       (lo_out)
  );

  // Scoreboard
  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference state, advanced once per active edge
  logic [31:0] m_hi, m_lo, m_count, m_status, m_cause, m_epc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hi = '0; m_lo = '0; m_count = '0;
    m_status = '0; m_cause = '0; m_epc = '0;
  endtask

  function automatic logic [31:0] cp0_rd(input logic [7:0] a);
    case (a)
      8'h48:   return m_count;
      8'h60:   return m_status;
      8'h68:   return m_cause;
      8'h70:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  // Driver: apply one slot at negedge, check outputs, advance the model
  task automatic drive(input logic v, input bus_t bb);
    exp_t e;
    exp_t g;
    logic commit;
    @(negedge clk);
    WB_valid = v;
    MEM_WB_bus_r = bb;
    e.wen      = v & bb.rf_wen & ~bb.ovf;
    e.wdest    = bb.wdest;
    e.wdata    = bb.mfhi ? m_hi : bb.mflo ? m_lo : bb.mfc0 ? cp0_rd(bb.addr) : bb.mem;
    e.exc      = v & (bb.ovf | bb.sys | bb.eret);
    e.exc_pc   = (v & (bb.ovf | bb.sys)) ? EXC_ADDR : (v & bb.eret) ? m_epc : 32'h0;
    e.wb_wdest = v ? bb.wdest : 5'd0;
    e.over     = v;
    e.pc       = bb.pc;
    e.hi       = m_hi;
    e.lo       = m_lo;
    exp_q.push_back(e);
    #1;
    g = exp_t'(exp_q.pop_front());
    check("rf_wen", {63'd0, rf_wen}, {63'd0, g.wen});
    check("rf_wdest", {59'd0, rf_wdest}, {59'd0, g.wdest});
    check("rf_wdata", {32'd0, rf_wdata}, {32'd0, g.wdata});
    check("exc_valid", {63'd0, exc_valid}, {63'd0, g.exc});
    check("exc_pc", {32'd0, exc_pc}, {32'd0, g.exc_pc});
    check("WB_wdest", {59'd0, WB_wdest}, {59'd0, g.wb_wdest});
    check("WB_over", {63'd0, WB_over}, {63'd0, g.over});
    check("WB_pc", {32'd0, WB_pc}, {32'd0, g.pc});
    check("hi_out", {32'd0, hi_out}, {32'd0, g.hi});
    check("lo_out", {32'd0, lo_out}, {32'd0, g.lo});
    // state after the coming edge
    commit = v & ~bb.ovf & ~bb.sys & ~bb.eret;
    if (commit & bb.mtc0 & (bb.addr == 8'h48)) m_count = bb.mem;
    else m_count = m_count + 32'd1;
    if (commit) begin
      if (bb.hi_w) m_hi = bb.mem;
      if (bb.lo_w) m_lo = bb.lo;
    end
    if (v & (bb.ovf | bb.sys)) begin
      m_epc = bb.pc;
      m_status[1] = 1'b1;
      m_cause[6:2] = bb.ovf ? 5'd12 : 5'd8;
    end else if (v & bb.eret) begin
      m_status[1] = 1'b0;
    end else if (commit & bb.mtc0) begin
      case (bb.addr)
        8'h60: m_status = bb.mem;
        8'h68: m_cause[9:8] = bb.mem[9:8];
        8'h70: m_epc = bb.mem;
        default: ;
      endcase
    end
  endtask

  task automatic rd_cp0(input logic [7:0] a);
    bus_t bb;
    bb = '0; bb.rf_wen = 1'b1; bb.wdest = 5'd3; bb.mfc0 = 1'b1; bb.addr = a;
    drive(1'b1, bb);
  endtask

  // Release reset just after an active edge so the model sees every edge
  task automatic release_reset();
    bus_t bb;
    @(posedge clk);
    #2;
    resetn = 1'b1;
    bb = '0;
    drive(1'b0, bb);
  endtask

  logic [7:0] addr_tbl [5] = '{8'h48, 8'h60, 8'h68, 8'h70, 8'h10};

  initial begin
    bus_t b;
    model_reset();

    // Reset state, with a syscall presented to prove exc_valid stays low
    #3;
    b = '0; b.sys = 1'b1; b.pc = 32'h40;
    WB_valid = 1'b1; MEM_WB_bus_r = b;
    #1;
    check("rst_exc_valid", {63'd0, exc_valid}, 64'd0);
    check("rst_hi", {32'd0, hi_out}, 64'd0);
    check("rst_lo", {32'd0, lo_out}, 64'd0);
    WB_valid = 1'b0; MEM_WB_bus_r = '0;
    repeat (2) @(posedge clk);
    release_reset();
    rd_cp0(8'h48); check("cnt_1", {32'd0, rf_wdata}, 64'd1);
    rd_cp0(8'h48); check("cnt_2", {32'd0, rf_wdata}, 64'd2);
    rd_cp0(8'h48); check("cnt_3", {32'd0, rf_wdata}, 64'd3);

    // HI/LO write, then read back in following cycles
    b = '0; b.hi_w = 1'b1; b.lo_w = 1'b1; b.mem = 32'h1234_5678; b.lo = 32'h9ABC_DEF0;
    drive(1'b1, b);
    b = '0; b.rf_wen = 1'b1; b.wdest = 5'd2; b.mfhi = 1'b1;
    drive(1'b1, b);
    check("mfhi_lit", {32'd0, rf_wdata}, 64'h1234_5678);
    check("mfhi_dest", {59'd0, rf_wdest}, 64'd2);
    b.mfhi = 1'b0; b.mflo = 1'b1;
    drive(1'b1, b);
    check("mflo_lit", {32'd0, rf_wdata}, 64'h9ABC_DEF0);

    // Overflow with a HI write that must be suppressed
    b = '0; b.rf_wen = 1'b1; b.wdest = 5'd7; b.ovf = 1'b1; b.pc = 32'hBFC0_0010;
    b.hi_w = 1'b1; b.mem = 32'hDEAD_BEEF;
    drive(1'b1, b);
    check("ovf_rf_wen", {63'd0, rf_wen}, 64'd0);
    check("ovf_exc_valid", {63'd0, exc_valid}, 64'd1);
    check("ovf_exc_pc", {32'd0, exc_pc}, 64'd0);
    rd_cp0(8'h70); check("ovf_epc", {32'd0, rf_wdata}, 64'hBFC0_0010);
    rd_cp0(8'h60); check("ovf_exl", {63'd0, rf_wdata[1]}, 64'd1);
    rd_cp0(8'h68); check("ovf_code", {59'd0, rf_wdata[6:2]}, 64'd12);
    check("ovf_hi_kept", {32'd0, hi_out}, 64'h1234_5678);

    // Syscall then eret
    b = '0; b.sys = 1'b1; b.pc = 32'h100;
    drive(1'b1, b);
    rd_cp0(8'h68); check("sys_code", {59'd0, rf_wdata[6:2]}, 64'd8);
    b = '0; b.eret = 1'b1; b.pc = 32'h300;
    drive(1'b1, b);
    check("eret_exc_valid", {63'd0, exc_valid}, 64'd1);
    check("eret_exc_pc", {32'd0, exc_pc}, 64'h100);
    rd_cp0(8'h60); check("eret_exl", {63'd0, rf_wdata[1]}, 64'd0);

    // mtc0: CAUSE only takes bits [9:8]; unmapped address ignored
    b = '0; b.mtc0 = 1'b1; b.addr = 8'h68; b.mem = 32'hFFFF_FFFF;
    drive(1'b1, b);
    rd_cp0(8'h68); check("cause_mask", {32'd0, rf_wdata}, 64'h320);
    b = '0; b.mtc0 = 1'b1; b.addr = 8'h10; b.mem = 32'h5555_AAAA;
    drive(1'b1, b);
    rd_cp0(8'h10); check("unmapped_rd", {32'd0, rf_wdata}, 64'd0);

    // COUNT write and wrap
    b = '0; b.mtc0 = 1'b1; b.addr = 8'h48; b.mem = 32'hFFFF_FFFE;
    drive(1'b1, b);
    rd_cp0(8'h48); check("cnt_wr", {32'd0, rf_wdata}, 64'hFFFF_FFFE);
    rd_cp0(8'h48); check("cnt_max", {32'd0, rf_wdata}, 64'hFFFF_FFFF);
    rd_cp0(8'h48); check("cnt_wrap", {32'd0, rf_wdata}, 64'd0);

    // Invalid slot carrying syscall and a HI write
    b = '0; b.sys = 1'b1; b.hi_w = 1'b1; b.mem = 32'hAAAA_AAAA; b.wdest = 5'd9; b.rf_wen = 1'b1;
    drive(1'b0, b);
    check("inv_exc_valid", {63'd0, exc_valid}, 64'd0);
    check("inv_wdest", {59'd0, WB_wdest}, 64'd0);
    b = '0;
    drive(1'b0, b);
    check("inv_hi_kept", {32'd0, hi_out}, 64'h1234_5678);

    // Random instructions
    for (int i = 0; i < 40; i++) begin
      b.rf_wen = 1'($urandom_range(0, 1));
      b.wdest  = 5'($urandom_range(0, 31));
      b.mem    = $urandom;
      b.lo     = $urandom;
      b.hi_w   = 1'($urandom_range(0, 1));
      b.lo_w   = 1'($urandom_range(0, 1));
      b.mfhi   = ($urandom_range(0, 3) == 0);
      b.mflo   = ($urandom_range(0, 3) == 0);
      b.mtc0   = ($urandom_range(0, 2) == 0);
      b.mfc0   = ($urandom_range(0, 2) == 0);
      b.addr   = addr_tbl[$urandom_range(0, 4)];
      b.sys    = ($urandom_range(0, 7) == 0);
      b.eret   = ($urandom_range(0, 7) == 0);
      b.ovf    = ($urandom_range(0, 7) == 0);
      b.pc     = $urandom;
      drive(($urandom_range(0, 4) != 0), b);
    end

    // Reset mid-instruction: pending HI/LO write discarded
    b = '0; b.hi_w = 1'b1; b.lo_w = 1'b1; b.mem = 32'h0F0F_0F0F; b.lo = 32'h7777_7777;
    drive(1'b1, b);
    #1;
    resetn = 1'b0;
    model_reset();
    b = '0; b.mfc0 = 1'b1; b.addr = 8'h60; b.sys = 1'b1;
    MEM_WB_bus_r = b;
    #1;
    check("mid_hi", {32'd0, hi_out}, 64'd0);
    check("mid_lo", {32'd0, lo_out}, 64'd0);
    check("mid_status", {32'd0, rf_wdata}, 64'd0);
    check("mid_exc_valid", {63'd0, exc_valid}, 64'd0);
    b.addr = 8'h70;
    MEM_WB_bus_r = b;
    #1;
    check("mid_epc", {32'd0, rf_wdata}, 64'd0);
    WB_valid = 1'b0; MEM_WB_bus_r = '0;
    release_reset();
    rd_cp0(8'h48); check("mid_cnt_1", {32'd0, rf_wdata}, 64'd1);
    rd_cp0(8'h48); check("mid_cnt_2", {32'd0, rf_wdata}, 64'd2);
    rd_cp0(8'h48); check("mid_cnt_3", {32'd0, rf_wdata}, 64'd3);

    if (exp_q.size() != 0) check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
